fetch_stage: RTL and testbench

- Instruction-fetch stage of the LEGv8 pipeline. It owns the PC register, drives the instruction-memory request, and loads the IF/ID pipeline register.
- The PC register feeds the instruction memory. The IF/ID register output feeds decode.
- It supports memory wait states, decode stall, flush, and branch redirect from a later stage.

---
 rtl/fetch_pkg.sv | 9 +
 rtl/flopenr.sv | 19 +
 rtl/fetch_stage.sv | 138 +++++++++++++
 tb/tb_fetch_stage.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the LEGv8 instruction-fetch stage.
package fetch_pkg;

  typedef enum logic {FETCH = 1'b0, BUFFERED = 1'b1} fetch_state_t;

  localparam int INSTR_W = 32;
  localparam int PC_INC  = 4;

endpackage

// File: rtl/flopenr.sv
// Resettable register with load enable; async active-high reset to RESET_VAL.
module flopenr #(
  parameter int             N         = 64,
  parameter logic [N-1:0]   RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)   q <= RESET_VAL;
    else if (en) q <= d;
  end

endmodule

// File: rtl/fetch_stage.sv
// LEGv8 fetch stage: PC register, instruction-memory request, skid buffer and IF/ID register.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int           N        = 64,
  parameter logic [N-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               flush,
  input  logic               br_taken,
  input  logic [N-1:0]       br_target,
  output logic [N-1:0]       imem_addr,
  output logic               imem_req,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_ready,
  output logic [N-1:0]       if_pc,
  output logic [INSTR_W-1:0] if_instr,
  output logic               if_valid
);

  fetch_state_t state_q, state_d;

  logic [N-1:0]       pc_q, pc_d;
  logic               pc_en;
  logic [N-1:0]       if_pc_q, if_pc_d;
  logic [INSTR_W-1:0] if_instr_q, if_instr_d;
  logic               ifid_en;
  logic               if_valid_q, if_valid_d;
  logic               valid_en;
  logic [N-1:0]       buf_pc_q;
  logic [INSTR_W-1:0] buf_instr_q;
  logic               buf_en;
  logic               accept;
  logic               unused_br_lsb;

  // Redirect targets are word-aligned by construction; the low bits carry no information.
  assign unused_br_lsb = ^br_target[1:0];

  assign accept = (state_q == FETCH) && imem_ready;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (br_taken || flush) begin
      state_d = FETCH;
    end else begin
      unique case (state_q)
        FETCH:    if (imem_ready && stall) state_d = BUFFERED;
        BUFFERED: if (!stall)              state_d = FETCH;
        default:                           state_d = FETCH;
      endcase
    end
  end

  // Output logic
  always_comb begin
    imem_req = !reset && (state_q == FETCH);
  end

  // Next-PC mux and register enables; priority br_taken > flush > stall.
  always_comb begin
    // NOTE: every comb output gets a default first, so no path can infer a latch.
    pc_en      = 1'b0;
    pc_d       = pc_q + N'(PC_INC);
    ifid_en    = 1'b0;
    valid_en   = 1'b0;
    if_valid_d = if_valid_q;
    buf_en     = 1'b0;
    if_pc_d    = (state_q == BUFFERED) ? buf_pc_q    : pc_q;
    if_instr_d = (state_q == BUFFERED) ? buf_instr_q : imem_rdata;

    if (br_taken) begin
      pc_en      = 1'b1;
      pc_d       = {br_target[N-1:2], 2'b00};
      valid_en   = 1'b1;
      if_valid_d = 1'b0;
    end else if (flush) begin
      // An accepted word still advances the PC; it is simply not written valid.
      pc_en      = accept;
      valid_en   = 1'b1;
      if_valid_d = 1'b0;
    end else if (state_q == FETCH) begin
      pc_en = imem_ready;
      if (imem_ready && !stall) begin
        ifid_en    = 1'b1;
        valid_en   = 1'b1;
        if_valid_d = 1'b1;
      end else if (imem_ready && stall) begin
        buf_en = 1'b1;
      end else if (!stall) begin
        valid_en   = 1'b1;
        if_valid_d = 1'b0;
      end
    end else if (!stall) begin
      ifid_en    = 1'b1;
      valid_en   = 1'b1;
      if_valid_d = 1'b1;
    end
  end

  flopenr #(.N(N), .RESET_VAL(RESET_PC)) u_pc (
    .clk(clk), .reset(reset), .en(pc_en), .d(pc_d), .q(pc_q)
  );

  flopenr #(.N(N)) u_if_pc (
    .clk(clk), .reset(reset), .en(ifid_en), .d(if_pc_d), .q(if_pc_q)
  );

  flopenr #(.N(INSTR_W)) u_if_instr (
    .clk(clk), .reset(reset), .en(ifid_en), .d(if_instr_d), .q(if_instr_q)
  );

  flopenr #(.N(1)) u_if_valid (
    .clk(clk), .reset(reset), .en(valid_en), .d(if_valid_d), .q(if_valid_q)
  );

  flopenr #(.N(N)) u_buf_pc (
    .clk(clk), .reset(reset), .en(buf_en), .d(pc_q), .q(buf_pc_q)
  );

  flopenr #(.N(INSTR_W)) u_buf_instr (
    .clk(clk), .reset(reset), .en(buf_en), .d(imem_rdata), .q(buf_instr_q)
  );

  assign imem_addr = pc_q;
  assign if_pc     = if_pc_q;
  assign if_instr  = if_instr_q;
  assign if_valid  = if_valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: expected IF/ID entries are queued when a word is accepted.
module tb_fetch_stage;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } entry_t;

  logic        clk;
  logic        reset, stall, flush, br_taken, imem_ready;
  logic [63:0] br_target;
  logic [31:0] imem_rdata;
  logic [63:0] imem_addr, if_pc;
  logic        imem_req, if_valid;
  logic [31:0] if_instr;

  logic        reset_w, ready_w, zero_w;
  logic [63:0] zero64_w;
  logic [31:0] rdata_w;
  logic [63:0] imem_addr_w, if_pc_w;
  logic        imem_req_w, if_valid_w;
  logic [31:0] if_instr_w;

  entry_t      sb_q[$];
  entry_t      e;
  logic [63:0] exp_pc;
  logic [63:0] last_pc;
  logic [31:0] last_instr;
  int          vectors = 0;
  int          errors  = 0;

  function automatic logic [31:0] word(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B9) ^ 32'h1234_5678;
  endfunction

  fetch_stage #(.N(64), .RESET_PC(64'h0)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .br_taken(br_taken), .br_target(br_target),
    .imem_addr(imem_addr), .imem_req(imem_req),
    .imem_rdata(imem_rdata), .imem_ready(imem_ready),
    .if_pc(if_pc), .if_instr(if_instr), .if_valid(if_valid)
  );

  fetch_stage #(.N(64), .RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dut_w (
    .clk(clk), .reset(reset_w), .stall(zero_w), .flush(zero_w),
    .br_taken(zero_w), .br_target(zero64_w),
    .imem_addr(imem_addr_w), .imem_req(imem_req_w),
    .imem_rdata(rdata_w), .imem_ready(ready_w),
    .if_pc(if_pc_w), .if_instr(if_instr_w), .if_valid(if_valid_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory model: word content depends only on the address.
  always_comb imem_rdata = word(imem_addr);
  always_comb rdata_w    = word(imem_addr_w);

  task automatic drive(input logic rdy, input logic st, input logic fl,
                       input logic br, input logic [63:0] tgt);
    @(negedge clk);
    imem_ready = rdy;
    stall      = st;
    flush      = fl;
    br_taken   = br;
    br_target  = tgt;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'b0; flush = 1'b0; br_taken = 1'b0;
    br_target = '0; imem_ready = 1'b0;
    tick();
    vectors++;
    if ({if_valid, if_pc, if_instr, imem_req, imem_addr} !== '0) begin
      errors++;
      $display("FAIL reset_state: valid=%0b pc=%h instr=%h req=%0b addr=%h, want all zero",
               if_valid, if_pc, if_instr, imem_req, imem_addr);
    end
    @(negedge clk);
    reset  = 1'b0;
    exp_pc = 64'h0;
  endtask

  task automatic test_stream(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
      vectors++;
      if (imem_addr !== exp_pc || imem_req !== 1'b1) begin
        errors++;
        $display("FAIL stream_req: addr=%h req=%0b, want addr=%h req=1", imem_addr, imem_req, exp_pc);
      end
      sb_q.push_back('{pc: exp_pc, instr: word(exp_pc)});
      exp_pc += 64'd4;
      tick();
      vectors++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL stream_out: scoreboard empty");
      end else begin
        e = sb_q.pop_front();
        if (if_valid !== 1'b1 || if_pc !== e.pc || if_instr !== e.instr) begin
          errors++;
          $display("FAIL stream_out: valid=%0b pc=%h instr=%h, want valid=1 pc=%h instr=%h",
                   if_valid, if_pc, if_instr, e.pc, e.instr);
        end
        last_pc    = e.pc;
        last_instr = e.instr;
      end
    end
  endtask

  task automatic test_wait_states();
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
      tick();
      vectors++;
      if (if_valid !== 1'b0 || imem_addr !== exp_pc || imem_req !== 1'b1) begin
        errors++;
        $display("FAIL wait_bubble: valid=%0b addr=%h req=%0b, want valid=0 addr=%h req=1",
                 if_valid, imem_addr, imem_req, exp_pc);
      end
    end
  endtask

  task automatic test_skid();
    drive(1'b1, 1'b1, 1'b0, 1'b0, '0);
    sb_q.push_back('{pc: exp_pc, instr: word(exp_pc)});
    exp_pc += 64'd4;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) drive(1'b1, 1'b1, 1'b0, 1'b0, '0);
      tick();
      vectors++;
      if (imem_req !== 1'b0 || imem_addr !== exp_pc || if_valid !== 1'b1 ||
          if_pc !== last_pc || if_instr !== last_instr) begin
        errors++;
        $display("FAIL skid_hold: req=%0b addr=%h valid=%0b pc=%h instr=%h, want req=0 addr=%h valid=1 pc=%h instr=%h",
                 imem_req, imem_addr, if_valid, if_pc, if_instr, exp_pc, last_pc, last_instr);
      end
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
    tick();
    vectors++;
    e = sb_q.pop_front();
    if (if_valid !== 1'b1 || if_pc !== e.pc || if_instr !== e.instr) begin
      errors++;
      $display("FAIL skid_release: valid=%0b pc=%h instr=%h, want valid=1 pc=%h instr=%h",
               if_valid, if_pc, if_instr, e.pc, e.instr);
    end
    vectors++;
    if (imem_req !== 1'b1 || imem_addr !== exp_pc) begin
      errors++;
      $display("FAIL skid_next: req=%0b addr=%h, want req=1 addr=%h", imem_req, imem_addr, exp_pc);
    end
  endtask

  task automatic test_branch_buffered();
    drive(1'b1, 1'b1, 1'b0, 1'b0, '0);
    tick();
    vectors++;
    if (imem_req !== 1'b0 || imem_addr !== exp_pc + 64'd4) begin
      errors++;
      $display("FAIL br_setup: req=%0b addr=%h, want req=0 addr=%h", imem_req, imem_addr, exp_pc + 64'd4);
    end
    drive(1'b1, 1'b1, 1'b0, 1'b1, 64'h103);
    tick();
    vectors++;
    if (if_valid !== 1'b0 || imem_addr !== 64'h100 || imem_req !== 1'b1) begin
      errors++;
      $display("FAIL br_redirect: valid=%0b addr=%h req=%0b, want valid=0 addr=100 req=1",
               if_valid, imem_addr, imem_req);
    end
    exp_pc = 64'h100;
    test_stream(1);
  endtask

  task automatic test_flush();
    drive(1'b1, 1'b1, 1'b1, 1'b0, '0);
    exp_pc += 64'd4;
    tick();
    vectors++;
    if (if_valid !== 1'b0 || imem_addr !== exp_pc || imem_req !== 1'b1) begin
      errors++;
      $display("FAIL flush_stall: valid=%0b addr=%h req=%0b, want valid=0 addr=%h req=1",
               if_valid, imem_addr, imem_req, exp_pc);
    end
    test_stream(1);
    drive(1'b1, 1'b1, 1'b0, 1'b0, '0);
    exp_pc += 64'd4;
    tick();
    vectors++;
    if (imem_req !== 1'b0 || if_valid !== 1'b1 || if_pc !== last_pc) begin
      errors++;
      $display("FAIL flush_buf_setup: req=%0b valid=%0b pc=%h, want req=0 valid=1 pc=%h",
               imem_req, if_valid, if_pc, last_pc);
    end
    drive(1'b0, 1'b0, 1'b1, 1'b0, '0);
    tick();
    vectors++;
    if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== exp_pc) begin
      errors++;
      $display("FAIL flush_buffered: valid=%0b req=%0b addr=%h, want valid=0 req=1 addr=%h",
               if_valid, imem_req, imem_addr, exp_pc);
    end
    test_stream(1);
  endtask

  task automatic test_wrap();
    @(negedge clk);
    reset_w = 1'b0;
    ready_w = 1'b1;
    #1;
    vectors++;
    if (imem_addr_w !== 64'hFFFF_FFFF_FFFF_FFFC || imem_req_w !== 1'b1) begin
      errors++;
      $display("FAIL wrap_start: addr=%h req=%0b, want addr=fffffffffffffffc req=1", imem_addr_w, imem_req_w);
    end
    tick();
    vectors++;
    if (if_valid_w !== 1'b1 || if_pc_w !== 64'hFFFF_FFFF_FFFF_FFFC ||
        if_instr_w !== word(64'hFFFF_FFFF_FFFF_FFFC) || imem_addr_w !== 64'h0) begin
      errors++;
      $display("FAIL wrap_next: valid=%0b pc=%h instr=%h addr=%h, want valid=1 pc=fffffffffffffffc instr=%h addr=0",
               if_valid_w, if_pc_w, if_instr_w, imem_addr_w, word(64'hFFFF_FFFF_FFFF_FFFC));
    end
    @(negedge clk);
    ready_w = 1'b0;
  endtask

  task automatic test_async_reset();
    drive(1'b1, 1'b1, 1'b0, 1'b0, '0);
    tick();
    vectors++;
    if (imem_req !== 1'b0 || if_valid !== 1'b1) begin
      errors++;
      $display("FAIL areset_setup: req=%0b valid=%0b, want req=0 valid=1", imem_req, if_valid);
    end
    #3;
    reset      = 1'b1;
    imem_ready = 1'b0;
    stall      = 1'b0;
    #1;
    vectors++;
    if ({if_valid, if_pc, if_instr, imem_req, imem_addr} !== '0) begin
      errors++;
      $display("FAIL areset_immediate: valid=%0b pc=%h instr=%h req=%0b addr=%h, want all zero",
               if_valid, if_pc, if_instr, imem_req, imem_addr);
    end
    @(negedge clk);
    reset  = 1'b0;
    exp_pc = 64'h0;
    test_stream(1);
  endtask

  initial begin
    reset_w  = 1'b1;
    ready_w  = 1'b0;
    zero_w   = 1'b0;
    zero64_w = '0;
    last_pc  = '0;
    last_instr = '0;
    test_reset();
    test_stream(2);
    test_wait_states();
    test_stream(2);
    test_skid();
    test_branch_buffered();
    test_flush();
    test_wrap();
    test_async_reset();
    vectors++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
